// File: rtl/kronos_divider.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// One operation in flight; request and response use valid/ready handshakes.
module kronos_divider #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [1:0]  divop,
    input  logic        req_valid,
    output logic        req_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] result
);

    // A transfer happens on any rising edge where valid and ready are both high;
    // valid-side payloads are only sampled on that edge.

    if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2) begin : g_bad_bits_per_cycle
        $error("kronos_divider: BITS_PER_CYCLE must be 1 or 2");
    end

    localparam logic [5:0] ITERS = 6'(32 / BITS_PER_CYCLE);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] divisor;
    logic [5:0]  count;
    logic        neg_q;
    logic        neg_r;
    logic        want_rem;

    logic        is_signed;
    logic [31:0] op1_abs;
    logic [31:0] op2_abs;
    logic        div_by_zero;
    logic        overflow;

    always_comb begin
        is_signed   = ~divop[0];
        op1_abs     = (is_signed && op1[31]) ? -op1 : op1;
        op2_abs     = (is_signed && op2[31]) ? -op2 : op2;
        div_by_zero = (op2 == 32'h0);
        overflow    = is_signed && (op1 == 32'h8000_0000) && (op2 == 32'hFFFF_FFFF);
    end

    // The shifted partial remainder can reach 33 bits before the subtract.
    logic [32:0] shifted;
    logic [31:0] rem_w;
    logic [31:0] quo_w;
    logic [31:0] quo_fin;
    logic [31:0] rem_fin;

    always_comb begin
        rem_w   = rem;
        quo_w   = quo;
        shifted = 33'h0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            shifted = {rem_w, quo_w[31]};
            if (shifted >= {1'b0, divisor}) begin
                shifted = shifted - {1'b0, divisor};
                quo_w   = {quo_w[30:0], 1'b1};
            end else begin
                quo_w   = {quo_w[30:0], 1'b0};
            end
            rem_w = shifted[31:0];
        end
        quo_fin = neg_q ? -quo_w : quo_w;
        rem_fin = neg_r ? -rem_w : rem_w;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            result    <= 32'h0;
            rem       <= 32'h0;
            quo       <= 32'h0;
            divisor   <= 32'h0;
            count     <= 6'h0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            want_rem  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        want_rem  <= divop[1];
                        neg_q     <= is_signed & (op1[31] ^ op2[31]);
                        neg_r     <= is_signed & op1[31];
                        divisor   <= op2_abs;
                        rem       <= 32'h0;
                        quo       <= op1_abs;
                        count     <= ITERS;
                        if (div_by_zero) begin
                            result    <= divop[1] ? op1 : 32'hFFFF_FFFF;
                            rsp_valid <= 1'b1;
                            state     <= DONE;
                        end else if (overflow) begin
                            result    <= divop[1] ? 32'h0 : 32'h8000_0000;
                            rsp_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem   <= rem_w;
                    quo   <= quo_w;
                    count <= count - 6'd1;
                    // Final step: register the signed-corrected result directly.
                    if (count == 6'd1) begin
                        result    <= want_rem ? rem_fin : quo_fin;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kronos_divider.sv
// Directed bench for kronos_divider; instance 0 uses 1 bit/cycle, instance 1 uses 2 bits/cycle.
module tb_kronos_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] op1 = 32'h0;
    logic [31:0] op2 = 32'h0;
    logic [1:0]  divop = 2'b00;
    logic        rsp_ready = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] result_w [2];

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    always #5 clk = ~clk;

    kronos_divider #(.BITS_PER_CYCLE(1)) dut_b1 (
        .clk(clk), .rst(rst), .op1(op1), .op2(op2), .divop(divop),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready), .result(result_w[0])
    );

    kronos_divider #(.BITS_PER_CYCLE(2)) dut_b2 (
        .clk(clk), .rst(rst), .op1(op1), .op2(op2), .divop(divop),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready), .result(result_w[1])
    );

    // Directed vectors: dividend, divisor, op, expected result, special-case flag
    localparam int NV = 12;
    logic [31:0] va [NV];
    logic [31:0] vb [NV];
    logic [1:0]  vo [NV];
    logic [31:0] ve [NV];
    bit          vs [NV];

    task automatic set_vec(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] op, input logic [31:0] e, input bit sp);
        va[i] = a; vb[i] = b; vo[i] = op; ve[i] = e; vs[i] = sp;
    endtask

    // Present one request; returns after the accepting edge with scrambled operands.
    task automatic send_req(input int sel, input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] op);
        @(negedge clk);
        op1 = a; op2 = b; divop = op;
        req_valid[sel] = 1'b1;
        @(posedge clk); #1;
        req_valid[sel] = 1'b0;
        op1 = $urandom; op2 = $urandom; divop = 2'($urandom_range(0, 3));
    endtask

    // Counts edges from the accepting edge (edge 1) to rsp_valid; bounded at 100.
    task automatic wait_rsp(input int sel, output int lat);
        lat = 1;
        while (rsp_valid[sel] !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic finish_rsp();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (req_ready[s] !== 1'b1 || rsp_valid[s] !== 1'b0 || result_w[s] !== 32'h0) begin
                errors++;
                $display("FAIL reset[%0d]: req_ready=%b rsp_valid=%b result=%h, want 1 0 00000000",
                         s, req_ready[s], rsp_valid[s], result_w[s]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_vectors();
        int lat;
        int exp_lat;
        set_vec(0,  32'd100,       32'd7,         OP_DIVU, 32'd14,        1'b0);
        set_vec(1,  32'd100,       32'd7,         OP_REMU, 32'd2,         1'b0);
        set_vec(2,  32'hFFFF_FFF9, 32'd2,         OP_DIV,  32'hFFFF_FFFD, 1'b0);
        set_vec(3,  32'hFFFF_FFF9, 32'd2,         OP_REM,  32'hFFFF_FFFF, 1'b0);
        set_vec(4,  32'd7,         32'hFFFF_FFFE, OP_REM,  32'd1,         1'b0);
        set_vec(5,  32'd5,         32'd0,         OP_DIVU, 32'hFFFF_FFFF, 1'b1);
        set_vec(6,  32'd5,         32'd0,         OP_REMU, 32'd5,         1'b1);
        set_vec(7,  32'hFFFF_FFFB, 32'd0,         OP_DIV,  32'hFFFF_FFFF, 1'b1);
        set_vec(8,  32'h8000_0000, 32'hFFFF_FFFF, OP_DIV,  32'h8000_0000, 1'b1);
        set_vec(9,  32'h8000_0000, 32'hFFFF_FFFF, OP_REM,  32'h0,         1'b1);
        set_vec(10, 32'h8000_0000, 32'hFFFF_FFFF, OP_DIVU, 32'h0,         1'b0);
        set_vec(11, 32'h8000_0000, 32'd2,         OP_DIV,  32'hC000_0000, 1'b0);
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < NV; i++) begin
                send_req(s, va[i], vb[i], vo[i]);
                wait_rsp(s, lat);
                exp_lat = vs[i] ? 1 : ((s == 0) ? 33 : 17);
                checks++;
                if (lat !== exp_lat) begin
                    errors++;
                    $display("FAIL latency[b%0d v%0d]: got %0d, want %0d", s + 1, i, lat, exp_lat);
                end
                checks++;
                if (result_w[s] !== ve[i]) begin
                    errors++;
                    $display("FAIL result[b%0d v%0d]: got %h, want %h", s + 1, i, result_w[s], ve[i]);
                end
                finish_rsp();
                checks++;
                if (rsp_valid[s] !== 1'b0 || req_ready[s] !== 1'b1) begin
                    errors++;
                    $display("FAIL release[b%0d v%0d]: rsp_valid=%b req_ready=%b, want 0 1",
                             s + 1, i, rsp_valid[s], req_ready[s]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        send_req(0, 32'd100, 32'd7, OP_DIVU);
        wait_rsp(0, lat);
        @(negedge clk);
        op1 = 32'd5; op2 = 32'd0; divop = OP_DIVU;
        req_valid[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            checks++;
            if (result_w[0] !== 32'd14 || rsp_valid[0] !== 1'b1 || req_ready[0] !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: result=%h rsp_valid=%b req_ready=%b, want 0000000e 1 0",
                         c, result_w[0], rsp_valid[0], req_ready[0]);
            end
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL held_req_not_taken: rsp_valid=%b req_ready=%b, want 0 1",
                     rsp_valid[0], req_ready[0]);
        end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        checks++;
        if (rsp_valid[0] !== 1'b1 || req_ready[0] !== 1'b0 || result_w[0] !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL held_req_taken: rsp_valid=%b req_ready=%b result=%h, want 1 0 ffffffff",
                     rsp_valid[0], req_ready[0], result_w[0]);
        end
        finish_rsp();
    endtask

    task automatic test_reset_mid_calc();
        int lat;
        send_req(0, 32'd100, 32'd7, OP_DIVU);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_calc: rsp_valid=%b req_ready=%b, want 0 1", rsp_valid[0], req_ready[0]);
        end
        // Reset and a request together: the request must be dropped.
        @(negedge clk);
        op1 = 32'd9; op2 = 32'd0; divop = OP_DIVU;
        req_valid[0] = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_vs_req: rsp_valid=%b req_ready=%b, want 0 1", rsp_valid[0], req_ready[0]);
        end
        req_valid[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle: rsp_valid=%b req_ready=%b, want 0 1", rsp_valid[0], req_ready[0]);
        end
        for (int s = 0; s < 2; s++) begin
            send_req(s, 32'hFFFF_FFFF, 32'h10, OP_DIVU);
            wait_rsp(s, lat);
            checks++;
            if (lat !== ((s == 0) ? 33 : 17) || result_w[s] !== 32'h0FFF_FFFF) begin
                errors++;
                $display("FAIL after_reset[b%0d]: latency=%0d result=%h, want %0d 0fffffff",
                         s + 1, lat, result_w[s], (s == 0) ? 33 : 17);
            end
            finish_rsp();
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid_calc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
